// File: rtl/seg_scan_controller_if.sv
// rtl/seg_scan_controller_if.sv - application/display bundle for the segment scan controller
interface seg_scan_controller_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic [3:0]  bcd_out;
    logic        select;
    logic [3:0]  anode;
    logic        frame_done;

    modport master (
        output load, value, digit_en, lz_suppress,
        input  bcd_out, select, anode, frame_done
    );

    modport slave (
        input  load, value, digit_en, lz_suppress,
        output bcd_out, select, anode, frame_done
    );
endinterface

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - 4-digit multiplexed BCD display scanner with blanking and double buffer
module seg_scan_controller #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 8,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_controller_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      active;
    logic [15:0]      pending;
    logic             pending_valid;

    logic             slot_end;
    logic             wrap;
    logic [15:0]      shifted;
    logic [3:0]       cur_nib;
    logic             show;
    logic             lz_dark;
    logic             dark;
    logic [3:0]       anode_nxt;

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == 2'd3);

    // Slot counter and digit index; index advances each time a slot completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads land in pending; active only changes on the frame wrap,
    // where a same-cycle load takes priority over an older pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            active        <= 16'd0;
            pending       <= 16'd0;
            pending_valid <= 1'b0;
        end else begin
            if (bus.load) begin
                pending <= bus.value;
            end
            if (wrap) begin
                if (bus.load) begin
                    active <= bus.value;
                end else if (pending_valid) begin
                    active <= pending;
                end
                pending_valid <= 1'b0;
            end else if (bus.load) begin
                pending_valid <= 1'b1;
            end
        end
    end

    // Display decode for the current slot; shifting the active value down by the
    // digit position leaves this nibble and all higher ones, so a zero result
    // means the digit is a leading zero.
    always_comb begin
        shifted   = active >> {idx, 2'b00};
        cur_nib   = shifted[3:0];
        show      = (cnt >= BLANK_END);
        lz_dark   = bus.lz_suppress && (idx != 2'd0) && (shifted == 16'd0);
        dark      = !bus.digit_en[idx] || lz_dark;
        anode_nxt = 4'hF;
        if (show && !dark) begin
            anode_nxt = ~(4'b0001 << idx);
        end
    end

    // Registered outputs, one cycle behind the counter state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bcd_out    <= 4'd0;
            bus.select     <= 1'b0;
            bus.anode      <= 4'hF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.bcd_out    <= cur_nib;
            bus.select     <= show;
            bus.anode      <= anode_nxt;
            bus.frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller
module tb_seg_scan_controller;

    localparam int SD = 10;
    localparam int BC = 2;
    localparam int FRAME = 4 * SD;

    logic clk = 1'b0;
    logic reset;
    seg_scan_controller_if bus ();

    seg_scan_controller #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: t = cycles since reset release
    int          t = 0;
    logic [15:0] m_act = 16'd0;
    logic [15:0] m_pend = 16'd0;
    logic        m_pv = 1'b0;
    logic [3:0]  cur_en = 4'hF;
    logic        cur_lz = 1'b0;
    int          cyc = 0;
    int          last_fd = -1;

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic ld, input logic [15:0] v);
        logic [3:0] e_bcd;
        logic       e_sel;
        logic [3:0] e_an;
        logic       e_fd;
        logic       dark;
        logic       allz;
        logic       wrap;
        int         c;
        int         d;
        reset = r;
        bus.load = ld;
        bus.value = v;
        bus.digit_en = cur_en;
        bus.lz_suppress = cur_lz;
        wrap = 1'b0;
        if (r) begin
            e_bcd = 4'd0; e_sel = 1'b0; e_an = 4'hF; e_fd = 1'b0;
        end else begin
            c = t % SD;
            d = (t / SD) % 4;
            e_bcd = nib(m_act, d);
            e_sel = (c >= BC);
            dark = !cur_en[d];
            if (cur_lz && d != 0) begin
                allz = 1'b1;
                for (int j = d; j < 4; j++) if (nib(m_act, j) != 4'd0) allz = 1'b0;
                dark = dark | allz;
            end
            e_an = 4'hF;
            if (e_sel && !dark) e_an[d] = 1'b0;
            wrap = ((t % FRAME) == FRAME - 1);
            e_fd = wrap;
        end
        if (r) begin
            t = 0; m_act = 16'd0; m_pend = 16'd0; m_pv = 1'b0;
        end else begin
            if (wrap) begin
                if (ld) m_act = v;
                else if (m_pv) m_act = m_pend;
                m_pv = 1'b0;
                if (ld) m_pend = v;
            end else if (ld) begin
                m_pend = v;
                m_pv = 1'b1;
            end
            t++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("bcd_out", 16'(bus.bcd_out), 16'(e_bcd));
        chk("select", 16'(bus.select), 16'(e_sel));
        chk("anode", 16'(bus.anode), 16'(e_an));
        chk("frame_done", 16'(bus.frame_done), 16'(e_fd));
        chk("anode_multihot", 16'($countones(~bus.anode) <= 1), 16'd1);
        if (r) begin
            last_fd = -1;
        end else if (bus.frame_done === 1'b1) begin
            if (last_fd >= 0) chk("frame_period", 16'(cyc - last_fd), 16'(FRAME));
            last_fd = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'd0);
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) tick(1'b0, 1'b0, 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.load = 1'b0;
        bus.value = 16'd0;
        bus.digit_en = 4'hF;
        bus.lz_suppress = 1'b0;

        tick(1'b1, 1'b0, 16'd0);
        tick(1'b1, 1'b0, 16'd0);

        // 1234 loaded right after reset; frame 0 still shows zeros
        tick(1'b0, 1'b1, 16'h1234);
        idle(40);
        run_to(34);
        chk("dir_d3_anode", 16'(bus.anode), 16'h0007);
        chk("dir_d3_bcd", 16'(bus.bcd_out), 16'h0001);
        idle(10);

        // leading zero suppression
        cur_lz = 1'b1;
        tick(1'b0, 1'b1, 16'h0070);
        idle(80);
        tick(1'b0, 1'b1, 16'h0000);
        idle(80);
        cur_lz = 1'b0;

        // two loads mid-frame, then a load exactly on the wrap cycle
        run_to(5);
        tick(1'b0, 1'b1, 16'h1111);
        idle(3);
        tick(1'b0, 1'b1, 16'h2222);
        run_to(39);
        idle(1);
        run_to(39);
        tick(1'b0, 1'b1, 16'h3333);
        idle(40);

        // per-digit enable
        cur_en = 4'b0101;
        tick(1'b0, 1'b1, 16'h5678);
        idle(85);
        cur_en = 4'hF;

        // reset during SHOW of digit 2
        run_to(25);
        tick(1'b1, 1'b0, 16'd0);
        chk("dir_rst_anode", 16'(bus.anode), 16'h000F);
        chk("dir_rst_select", 16'(bus.select), 16'h0000);
        idle(45);

        // randomized traffic
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) cur_lz = ~cur_lz;
            tick(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
